uart_receiver: RTL and testbench



---
 rtl/uart_receiver_pkg.sv | 14 +
 rtl/uart_receiver_if.sv | 22 ++
 rtl/uart_receiver_synchronizer.sv | 28 ++
 rtl/uart_receiver.sv | 121 ++++++++++++
 tb/tb_uart_receiver.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg: shared UART frame constants and FSM encoding.
// Imported by the receiver and its testbench.
package uart_receiver_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: received-byte valid/ready channel.
// master = receiver side, slave = CPU-side MMIO consumer.
interface uart_receiver_if;
  import uart_receiver_pkg::*;

  logic [DATA_BITS-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;

  modport master (
    output data_out,
    output data_out_valid,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    output data_out_ready
  );

endinterface

// File: rtl/uart_receiver_synchronizer.sv
// uart_receiver_synchronizer: two-stage flop synchronizer with
// configurable width and reset value.
module uart_receiver_synchronizer #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receive stage with a one-byte
// holding register, framing-error and overrun pulses.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serial_in,
  uart_receiver_if.master rx_if,
  output logic framing_error,
  output logic overrun
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev_q;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 fe_q;
  logic                 ov_q;

  logic fall;
  logic accept;

  uart_receiver_synchronizer #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (serial_in),
    .q_o   (rx_s)
  );

  assign fall   = rx_prev_q & ~rx_s;
  assign accept = valid_q & rx_if.data_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rx_prev_q <= rx_s;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      if (accept) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == MID_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == SYM_LAST) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_q   <= '0;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == SYM_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            // A byte accepted this same cycle frees the register
            if (!rx_s) begin
              fe_q <= 1'b1;
            end else if (valid_q && !rx_if.data_out_ready) begin
              ov_q <= 1'b1;
            end else begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_if.data_out       = data_q;
  assign rx_if.data_out_valid = valid_q;
  assign framing_error        = fe_q;
  assign overrun              = ov_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames at 5 clocks per bit
// with hand-computed expected bytes, pulses and latency.
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  logic clk;
  logic rst_n;
  logic serial_in;
  logic framing_error;
  logic overrun;

  uart_receiver_if u_if ();

  uart_receiver #(
    .CLOCK_FREQ (50_000_000),
    .BAUD_RATE  (10_000_000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .serial_in     (serial_in),
    .rx_if         (u_if.master),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] hs_q[$];
  int valid_hi;
  int fe_cnt;
  int ov_cnt;
  int rise_cyc;
  logic vprev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.data_out_valid) begin
      valid_hi++;
      if (u_if.data_out_ready) hs_q.push_back(u_if.data_out);
    end
    if (u_if.data_out_valid && !vprev) rise_cyc = cyc;
    vprev = u_if.data_out_valid;
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hs_at(input int i);
    return (hs_q.size() > i) ? hs_q[i] : 8'hxx;
  endfunction

  task automatic clr_mon();
    hs_q.delete();
    valid_hi = 0;
    fe_cnt   = 0;
    ov_cnt   = 0;
    rise_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = f[i];
      idle(5);
    end
  endtask

  int t0;

  initial begin
    rst_n = 1'b0;
    serial_in = 1'b1;
    u_if.data_out_ready = 1'b1;
    clr_mon();
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(u_if.data_out), 32'h00);
    chk("rst_valid", 32'(u_if.data_out_valid), 0);
    chk("rst_fe", 32'(framing_error), 0);
    chk("rst_ov", 32'(overrun), 0);
    idle(1);
    rst_n = 1'b1;
    idle(5);

    clr_mon();
    t0 = cyc;
    send(8'hA5, 1'b1);
    idle(3);
    chk("a5_count", hs_q.size(), 1);
    chk("a5_data", 32'(hs_at(0)), 32'hA5);
    chk("a5_latency", 32'(rise_cyc - t0 >= 49 && rise_cyc - t0 <= 51), 1);
    chk("a5_width", valid_hi, 1);

    clr_mon();
    send(8'h61, 1'b1);
    send(8'h62, 1'b1);
    idle(3);
    chk("b2b_count", hs_q.size(), 2);
    chk("b2b_first", 32'(hs_at(0)), 32'h61);
    chk("b2b_second", 32'(hs_at(1)), 32'h62);
    chk("b2b_errs", fe_cnt + ov_cnt, 0);

    clr_mon();
    u_if.data_out_ready = 1'b0;
    send(8'h33, 1'b1);
    send(8'h34, 1'b1);
    idle(3);
    chk("ovr_valid", 32'(u_if.data_out_valid), 1);
    chk("ovr_data", 32'(u_if.data_out), 32'h33);
    chk("ovr_pulses", ov_cnt, 1);
    u_if.data_out_ready = 1'b1;
    idle(2);
    chk("ovr_drain_n", hs_q.size(), 1);
    chk("ovr_drain", 32'(hs_at(0)), 32'h33);
    chk("ovr_valid_lo", 32'(u_if.data_out_valid), 0);

    clr_mon();
    send(8'h55, 1'b0);
    serial_in = 1'b1;
    idle(10);
    chk("fe_pulses", fe_cnt, 1);
    chk("fe_novalid", valid_hi, 0);
    send(8'h0d, 1'b1);
    idle(3);
    chk("fe_next", 32'(hs_at(0)), 32'h0d);
    chk("fe_next_n", hs_q.size(), 1);

    clr_mon();
    serial_in = 1'b0;
    idle(2);
    serial_in = 1'b1;
    idle(3);
    chk("glitch_idle", 32'(dut.state_q), 32'(IDLE));
    idle(60);
    chk("glitch_quiet", valid_hi + fe_cnt + ov_cnt, 0);

    clr_mon();
    serial_in = 1'b0;
    idle(5);
    serial_in = 1'b1;
    idle(12);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(u_if.data_out), 32'h00);
    chk("arst_valid", 32'(u_if.data_out_valid), 0);
    chk("arst_state", 32'(dut.state_q), 32'(IDLE));
    idle(2);
    rst_n = 1'b1;
    idle(60);
    clr_mon();
    send(8'h3e, 1'b1);
    idle(3);
    chk("arst_next_n", hs_q.size(), 1);
    chk("arst_next", 32'(hs_at(0)), 32'h3e);
    chk("arst_errs", fe_cnt + ov_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
